xadc_argmax_seq: RTL

XADC_ARGMAX_SEQ -- requirements
Module: xadc_argmax_seq

---
 rtl/xadc_argmax_seq_pkg.sv | 29 ++
 rtl/xadc_argmax_seq_argmax_step.sv | 34 +++
 rtl/xadc_argmax_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/xadc_argmax_seq_pkg.sv
// xadc_argmax_seq_pkg
//   Shared definitions for the XADC auxiliary-channel argmax sequencer:
//   FSM state encoding, xadc_config bit-field positions, DRP constants and
//   the index-width helper.
package xadc_argmax_seq_pkg;

  localparam int unsigned DRP_AW = 7;
  localparam int unsigned DRP_DW = 16;
  localparam logic [DRP_AW-1:0] DRP_BASE_ADDR_DEF = 7'h10;

  // xadc_config fields
  localparam int unsigned CFG_EN_BIT  = 0;
  localparam int unsigned CFG_THR_LSB = 16;
  localparam int unsigned CFG_THR_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EOS  = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DRDY = 3'd3,
    ST_DECIDE    = 3'd4
  } state_t;

  // max(1, clog2(n))
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xadc_argmax_seq_argmax_step.sv
// argmax_step
//   Combinational compare-and-select for one argmax step.
//   i_first        : candidate is channel 0, take it unconditionally
//   i_cur_idx/val  : running maximum so far
//   i_new_idx/val  : candidate sample
//   o_idx/o_val    : updated running maximum (strictly greater wins, so
//                    ties keep the lower index)
module argmax_step #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                i_first,
  input  logic [IDX_W-1:0]    i_cur_idx,
  input  logic [SAMPLE_W-1:0] i_cur_val,
  input  logic [IDX_W-1:0]    i_new_idx,
  input  logic [SAMPLE_W-1:0] i_new_val,
  output logic [IDX_W-1:0]    o_idx,
  output logic [SAMPLE_W-1:0] o_val
);

  logic w_take_new;

  assign w_take_new = i_first || (i_new_val > i_cur_val);

  always_comb begin
    o_idx = i_cur_idx;
    o_val = i_cur_val;
    if (w_take_new) begin
      o_idx = i_new_idx;
      o_val = i_new_val;
    end
  end

endmodule

// File: rtl/xadc_argmax_seq.sv
// xadc_argmax_seq
//   After each XADC end-of-sequence pulse, reads NUM_CH auxiliary channels
//   over the DRP (addresses BASE_ADDR..BASE_ADDR+NUM_CH-1) and publishes the
//   index and value of the largest sample.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     xadc_config     : bit0 enable, bits[27:16] threshold
//     BUSY            : unused
//     DO, DRDY        : DRP read data / data-ready
//     EOS             : end-of-sequence pulse, starts a sweep
//     DADDR, DEN      : DRP address / one-cycle enable
//     DI, DWE         : DRP write data / write enable, tied to 0
//     network_output  : index of largest channel from last completed sweep
//     max_value       : sample value at network_output
//     class_valid     : one-cycle pulse when results update
//     below_thresh    : max_value < threshold for last completed sweep
//     drp_timeout     : sticky DRDY-timeout error
module xadc_argmax_seq
  import xadc_argmax_seq_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter logic [DRP_AW-1:0] BASE_ADDR = DRP_BASE_ADDR_DEF,
  parameter int unsigned       SAMPLE_W  = 12,
  parameter int unsigned       TIMEOUT   = 64,
  localparam int unsigned      IDX_W     = idx_width(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         xadc_config,
  input  logic                BUSY,
  input  logic [DRP_DW-1:0]   DO,
  input  logic                DRDY,
  input  logic                EOS,
  output logic [DRP_AW-1:0]   DADDR,
  output logic                DEN,
  output logic [DRP_DW-1:0]   DI,
  output logic                DWE,
  output logic [IDX_W-1:0]    network_output,
  output logic [SAMPLE_W-1:0] max_value,
  output logic                class_valid,
  output logic                below_thresh,
  output logic                drp_timeout
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_ch;
  logic [TO_W-1:0]     r_to_cnt;
  logic [IDX_W-1:0]    r_max_idx;
  logic [SAMPLE_W-1:0] r_max_val;
  logic [DRP_AW-1:0]   r_daddr;
  logic                r_den;
  logic [IDX_W-1:0]    r_net_out;
  logic [SAMPLE_W-1:0] r_max_out;
  logic                r_class_valid;
  logic                r_below;
  logic                r_timeout;

  logic                w_en;
  logic [15:0]         w_thr_ext;
  logic [SAMPLE_W-1:0] w_thr;
  logic [SAMPLE_W-1:0] w_sample;
  logic [IDX_W-1:0]    w_ch_nxt;
  logic [IDX_W-1:0]    w_step_idx;
  logic [SAMPLE_W-1:0] w_step_val;
  logic                w_unused;

  assign w_en      = xadc_config[CFG_EN_BIT];
  assign w_thr_ext = 16'(xadc_config[CFG_THR_LSB +: CFG_THR_W]);
  assign w_thr     = w_thr_ext[SAMPLE_W-1:0];
  assign w_sample  = DO[DRP_DW-1 -: SAMPLE_W];
  assign w_ch_nxt  = r_ch + IDX_W'(1);
  assign w_unused  = ^{BUSY, xadc_config, DO};

  argmax_step #(
    .SAMPLE_W (SAMPLE_W),
    .IDX_W    (IDX_W)
  ) u_step (
    .i_first   (r_ch == '0),
    .i_cur_idx (r_max_idx),
    .i_cur_val (r_max_val),
    .i_new_idx (r_ch),
    .i_new_val (w_sample),
    .o_idx     (w_step_idx),
    .o_val     (w_step_val)
  );

  // Results are published on the edge that leaves WAIT_DRDY with the last
  // sample, using the argmax_step output directly, so the DECIDE cycle is
  // the one where class_valid and the new results are visible. This keeps
  // class_valid exactly one cycle after the final DRDY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ch          <= '0;
      r_to_cnt      <= '0;
      r_max_idx     <= '0;
      r_max_val     <= '0;
      r_daddr       <= '0;
      r_den         <= 1'b0;
      r_net_out     <= '0;
      r_max_out     <= '0;
      r_class_valid <= 1'b0;
      r_below       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_den         <= 1'b0;
      r_class_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_en) r_state <= ST_WAIT_EOS;
        end
        ST_WAIT_EOS: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (EOS) begin
            r_ch    <= '0;
            r_daddr <= BASE_ADDR;
            r_den   <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_DRDY;
          end
        end
        ST_WAIT_DRDY: begin
          if (DRDY) begin
            r_max_idx <= w_step_idx;
            r_max_val <= w_step_val;
            if (r_ch == LAST_CH) begin
              r_net_out     <= w_step_idx;
              r_max_out     <= w_step_val;
              r_below       <= (w_step_val < w_thr);
              r_class_valid <= 1'b1;
              r_state       <= ST_DECIDE;
            end else if (!w_en) begin
              // read finished; stop before issuing the next one
              r_state <= ST_IDLE;
            end else begin
              r_ch    <= w_ch_nxt;
              r_daddr <= BASE_ADDR + DRP_AW'(w_ch_nxt);
              r_den   <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_WAIT_EOS;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_DECIDE: begin
          r_state <= w_en ? ST_WAIT_EOS : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DADDR          = r_daddr;
  assign DEN            = r_den;
  assign DI             = '0;
  assign DWE            = 1'b0;
  assign network_output = r_net_out;
  assign max_value      = r_max_out;
  assign class_valid    = r_class_valid;
  assign below_thresh   = r_below;
  assign drp_timeout    = r_timeout;

endmodule
